// File: rtl/cla_pkg.sv
// Shared constants, segment-width helper and the stage-register record for the
// pipelined carry-lookahead adder/subtractor.
package cla_pkg;

  localparam int CLA_WIDTH     = 64;
  localparam int CLA_STAGES    = 4;
  // Stage records are sized for the widest supported operand; WIDTH must not exceed this.
  localparam int CLA_MAX_WIDTH = 64;

  function automatic int seg_width(input int width, input int stages);
    return width / stages;
  endfunction

  typedef struct packed {
    logic                     valid;
    logic [CLA_MAX_WIDTH-1:0] a;
    logic [CLA_MAX_WIDTH-1:0] b;
    logic                     sub;
    logic                     carry;
    logic [CLA_MAX_WIDTH-1:0] psum;
  } cla_stage_t;

endpackage

// File: rtl/cla_segment.sv
// Combinational SEG-bit carry-lookahead adder; also exposes the carry into its MSB
// so the top segment can derive signed overflow.
module cla_segment #(
  parameter int SEG = 16
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           cmsb
);

  logic [SEG-1:0] g;
  logic [SEG-1:0] p;
  logic [SEG:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is the flat sum-of-products over all lower generate terms and cin.
  always_comb begin
    logic prop;
    c    = '0;
    prop = 1'b0;
    c[0] = cin;
    for (int i = 0; i < SEG; i++) begin
      c[i+1] = g[i];
      prop   = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (prop & g[j]);
        prop   = prop & p[j];
      end
      c[i+1] = c[i+1] | (prop & cin);
    end
  end

  assign sum  = p ^ c[SEG-1:0];
  assign cout = c[SEG];
  assign cmsb = c[SEG-1];

endmodule

// File: rtl/pipelined_cla_addsub.sv
// STAGES-deep add/subtract pipeline: one CLA segment per stage, operands delayed and
// partial sums forwarded so every stage register carries one whole transaction.
module pipelined_cla_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH  = CLA_WIDTH,
  parameter int STAGES = CLA_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int SEG = seg_width(WIDTH, STAGES);

  cla_stage_t       st_q [STAGES];
  cla_stage_t       st_d [STAGES];
  logic [SEG-1:0]   seg_sum  [STAGES];
  logic             seg_cout [STAGES];
  logic             seg_cmsb [STAGES];

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             advance;

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_seg
      logic [SEG-1:0] b_seg;
      assign b_seg = st_q[gi].sub ? ~st_q[gi].b[gi*SEG +: SEG] : st_q[gi].b[gi*SEG +: SEG];
      cla_segment #(.SEG(SEG)) u_seg (
        .a    (st_q[gi].a[gi*SEG +: SEG]),
        .b    (b_seg),
        .cin  (st_q[gi].carry),
        .sum  (seg_sum[gi]),
        .cout (seg_cout[gi]),
        .cmsb (seg_cmsb[gi])
      );
    end
  endgenerate

  // Stage 0 only captures operands; stage k+1 receives stage k's segment result.
  always_comb begin
    st_d[0]                  = '0;
    st_d[0].valid            = in_valid;
    st_d[0].a[WIDTH-1:0]     = a;
    st_d[0].b[WIDTH-1:0]     = b;
    st_d[0].sub              = sub;
    st_d[0].carry            = sub ? 1'b1 : cin;
    for (int k = 1; k < STAGES; k++) begin
      st_d[k]                        = st_q[k-1];
      st_d[k].carry                  = seg_cout[k-1];
      st_d[k].psum[(k-1)*SEG +: SEG] = seg_sum[k-1];
    end
  end

  always_comb begin
    out_valid_d                 = st_q[STAGES-1].valid;
    result_d                    = st_q[STAGES-1].psum[WIDTH-1:0];
    result_d[WIDTH-SEG +: SEG]  = seg_sum[STAGES-1];
    cout_d                      = seg_cout[STAGES-1];
    ovf_d                       = seg_cmsb[STAGES-1] ^ seg_cout[STAGES-1];
    zero_d                      = (result_d == '0);
    if (!out_valid_d) begin
      result_d = '0;
      cout_d   = 1'b0;
      ovf_d    = 1'b0;
      zero_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) st_q[k] <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) st_q[k] <= st_d[k];
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Directed and random checks of pipelined_cla_addsub (64-bit; 4 stages for directed
// steps, 1/2/4/8 stages for the random regression).
module tb_pipelined_cla_addsub;

  localparam int W     = 64;
  localparam int NRAND = 200;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, out_ready, cin, sub;
  logic [W-1:0]  a, b;
  logic          in_ready, out_valid, cout, overflow, zero;
  logic [W-1:0]  result;

  logic [3:0]         rv_valid, rv_rdy, rv_cout, rv_ovf, rv_zero;
  logic [3:0][W-1:0]  rv_res;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipelined_cla_addsub #(.WIDTH(W), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .cout(cout), .overflow(overflow), .zero(zero)
  );

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_alt
      localparam int ST = (gi == 0) ? 1 : (gi == 1) ? 2 : 8;
      pipelined_cla_addsub #(.WIDTH(W), .STAGES(ST)) u_alt (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rv_rdy[gi]),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(rv_valid[gi]), .out_ready(out_ready), .result(rv_res[gi]),
        .cout(rv_cout[gi]), .overflow(rv_ovf[gi]), .zero(rv_zero[gi])
      );
    end
  endgenerate

  assign rv_valid[3] = out_valid;
  assign rv_rdy[3]   = in_ready;
  assign rv_res[3]   = result;
  assign rv_cout[3]  = cout;
  assign rv_ovf[3]   = overflow;
  assign rv_zero[3]  = zero;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic run_one(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_b,
                         input logic tcin, input logic tsub, input logic [W-1:0] er,
                         input logic ec, input logic eo, input logic ez);
    int lat;
    @(negedge clk);
    a = ta; b = tb_b; cin = tcin; sub = tsub; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    $display("txn %s: a=%h b=%h cin=%0d sub=%0d -> result=%h cout=%0d ovf=%0d zero=%0d lat=%0d",
             tag, ta, tb_b, tcin, tsub, result, cout, overflow, zero, lat);
    check({tag, "_latency"}, lat, 4);
    check({tag, "_result"}, result, er);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_overflow"}, overflow, eo);
    check({tag, "_zero"}, zero, ez);
  endtask

  logic [W+2:0] held, exp_arr [NRAND];
  logic [W-1:0] ra, rb, rr, bv;
  logic         rs, rc, rco;
  int           sent, recv, stale;
  int           rx [4];
  bit           held_valid;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_flags", {cout, overflow, zero}, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    run_one("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
    run_one("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
    run_one("add_cin", 64'd1, 64'd1, 1'b1, 1'b0, 64'd3, 1'b0, 1'b0, 1'b0);
    run_one("sub_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
    run_one("sub_pos", 64'd5, 64'd3, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0, 1'b0);
    run_one("sub_eq", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b1, 64'd0, 1'b1, 1'b0, 1'b1);
    run_one("sub_neg", 64'd3, 64'd5, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);

    // Back-to-back stream with a four-cycle downstream stall.
    sent = 0; recv = 0; held_valid = 1'b0; held = '0;
    for (int c = 0; c < 40 && recv < 8; c++) begin
      @(negedge clk);
      out_ready = !(c >= 6 && c < 10);
      in_valid  = (sent < 8);
      a = 64'(sent); b = 64'(sent); cin = 1'b0; sub = 1'b0;
      #1;
      if (out_valid && !out_ready) begin
        check("stall_in_ready", in_ready, 0);
        if (held_valid) check("stall_hold", {result, cout, overflow, zero}, held);
        held = {result, cout, overflow, zero};
        held_valid = 1'b1;
      end else begin
        held_valid = 1'b0;
      end
      if (out_valid && out_ready) begin
        $display("txn stream[%0d]: result=%0d", recv, result);
        check("stream_result", result, 64'(2 * recv));
        recv++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    check("stream_count", recv, 8);

    // Asynchronous reset with transactions in flight.
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = 64'(100 + i); b = 64'(i); cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("inflight_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    $display("txn async_reset: out_valid=%0d result=%h in_ready=%0d", out_valid, result, in_ready);
    check("async_rst_valid", out_valid, 0);
    check("async_rst_result", result, 0);
    check("async_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("no_stale", stale, 0);
    run_one("post_rst", 64'd40, 64'd2, 1'b0, 1'b0, 64'd42, 1'b0, 1'b0, 1'b0);

    // Random regression across 1, 2, 4 and 8 stages.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) rx[k] = 0;
    for (int i = 0; i < NRAND + 12; i++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (rv_valid[k]) begin
          if (rx[k] < NRAND)
            check($sformatf("rand_dut%0d_%0d", k, rx[k]),
                  {rv_res[k], rv_cout[k], rv_ovf[k], rv_zero[k]}, exp_arr[rx[k]]);
          rx[k]++;
        end
      end
      check("rand_in_ready", rv_rdy, 4'hF);
      if (i < NRAND) begin
        ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
        rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
        if (i % 16 == 0) rb = rs ? ra : ~ra;
        rr  = rs ? ra - rb : ra + rb + 64'(rc);
        bv  = rs ? ~rb : rb;
        rco = ({1'b0, ra} + {1'b0, bv} + 65'(rs ? 1'b1 : rc)) >> W;
        exp_arr[i] = {rr, rco, (ra[W-1] == bv[W-1]) && (rr[W-1] != ra[W-1]), rr == '0};
        $display("txn rand[%0d]: a=%h b=%h cin=%0d sub=%0d -> expect %h", i, ra, rb, rc, rs, rr);
        a = ra; b = rb; sub = rs; cin = rc; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
    for (int k = 0; k < 4; k++) check($sformatf("rand_count_dut%0d", k), rx[k], NRAND);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
